// File: rtl/rmst_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// rmst_arbiter
// Shares one read master and its return stream between two requesters,
// IFM and WGT. A granted requester gets its address and transfer size issued
// to the read master. The shared stream is then routed to that requester
// until the read master reports completion.
//
// Configuration macro:
//   RMST_ARB_RR_EN  defined   -> simultaneous requests alternate (round robin)
//                   undefined -> IFM always wins simultaneous requests
//
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   ifm_req/wgt_req                 level requests, held until matching done
//   ifm/wgt_addr_base, _offset      transfer address = base + offset (mod 2^64)
//   ifm_done/wgt_done               one-cycle completion pulse to requester
//   ifm/wgt_tvalid, _tdata, _tready routed stream per requester
//   rmst_start/addr/size/done       shared read-master command/completion
//   s_tvalid/s_tdata/s_tready       shared read-master stream
//   grant                           one-hot owner (bit0 IFM, bit1 WGT)
//   busy                            high whenever not IDLE
//   xfer_err                        sticky beat-count mismatch flag
// -----------------------------------------------------------------------------
module rmst_arbiter #(
    parameter int DATA_WIDTH     = 512,
    parameter int IFM_XFER_BYTES = 46080,
    parameter int WGT_XFER_BYTES = 18432
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ifm_req,
    input  logic                  wgt_req,
    input  logic [63:0]           ifm_addr_base,
    input  logic [63:0]           wgt_addr_base,
    input  logic [63:0]           ifm_offset,
    input  logic [63:0]           wgt_offset,
    output logic                  ifm_done,
    output logic                  wgt_done,
    output logic                  ifm_tvalid,
    output logic                  wgt_tvalid,
    output logic [DATA_WIDTH-1:0] ifm_tdata,
    output logic [DATA_WIDTH-1:0] wgt_tdata,
    input  logic                  ifm_tready,
    input  logic                  wgt_tready,
    output logic                  rmst_start,
    output logic [63:0]           rmst_addr,
    output logic [63:0]           rmst_size,
    input  logic                  rmst_done,
    input  logic                  s_tvalid,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    output logic                  s_tready,
    output logic [1:0]            grant,
    output logic                  busy,
    output logic                  xfer_err
);

    localparam int BEAT_BYTES = DATA_WIDTH / 8;
    localparam int MAX_BYTES  = (IFM_XFER_BYTES > WGT_XFER_BYTES) ? IFM_XFER_BYTES : WGT_XFER_BYTES;
    localparam int MAX_BEATS  = MAX_BYTES / BEAT_BYTES;
    // One spare code above the largest legal count so an overrun cannot
    // wrap back onto a matching value.
    localparam int BEAT_W     = $clog2(MAX_BEATS + 2);

    localparam logic [63:0] IFM_SIZE    = 64'(IFM_XFER_BYTES);
    localparam logic [63:0] WGT_SIZE    = 64'(WGT_XFER_BYTES);
    localparam logic [63:0] BEAT_BYTES64 = 64'(BEAT_BYTES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_XFER  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          grant_q, grant_d;
    logic [63:0]         addr_q, addr_d;
    logic [63:0]         size_q, size_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic                err_q, err_d;
    logic                start_q, start_d;

    logic                in_xfer;
    logic                beat_fire;
    logic [63:0]         beat_total;
    logic                pick_wgt;

    // ---------------------------------------------------------------- arbitration
`ifdef RMST_ARB_RR_EN
    // 1 = WGT was granted last, so IFM wins the next tie.
    logic wgt_last_q, wgt_last_d;

    always_comb begin
        wgt_last_d = wgt_last_q;
        if (state_q == ST_DONE) begin
            wgt_last_d = grant_q[1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wgt_last_q <= 1'b1;
        end else begin
            wgt_last_q <= wgt_last_d;
        end
    end

    assign pick_wgt = wgt_req & (~ifm_req | ~wgt_last_q);
`else
    assign pick_wgt = wgt_req & ~ifm_req;
`endif

    // ---------------------------------------------------------------- stream routing
    assign in_xfer    = (state_q == ST_XFER);
    assign ifm_tdata  = s_tdata;
    assign wgt_tdata  = s_tdata;
    assign ifm_tvalid = in_xfer & grant_q[0] & s_tvalid;
    assign wgt_tvalid = in_xfer & grant_q[1] & s_tvalid;
    assign s_tready   = in_xfer & ((grant_q[0] & ifm_tready) | (grant_q[1] & wgt_tready));
    assign beat_fire  = in_xfer & s_tvalid & s_tready;

    // Include a beat that handshakes in the same cycle as rmst_done.
    assign beat_total = 64'(beat_q) + 64'(beat_fire);

    // ---------------------------------------------------------------- next state
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        grant_d = grant_q;
        addr_d  = addr_q;
        size_d  = size_q;
        beat_d  = beat_q;
        err_d   = err_q;
        start_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ifm_req | wgt_req) begin
                    grant_d = pick_wgt ? 2'b10 : 2'b01;
                    addr_d  = pick_wgt ? (wgt_addr_base + wgt_offset)
                                       : (ifm_addr_base + ifm_offset);
                    size_d  = pick_wgt ? WGT_SIZE : IFM_SIZE;
                    beat_d  = '0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Registered start: high for exactly the first XFER cycle.
                start_d = 1'b1;
                state_d = ST_XFER;
            end
            ST_XFER: begin
                if (beat_fire && (beat_q != '1)) begin
                    beat_d = beat_q + 1'b1;
                end
                if (rmst_done) begin
                    state_d = ST_DONE;
                    if (beat_total != (size_q / BEAT_BYTES64)) begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                grant_d = 2'b00;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= 2'b00;
            addr_q  <= '0;
            size_q  <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
            start_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
            start_q <= start_d;
        end
    end

    // ---------------------------------------------------------------- outputs
    assign ifm_done   = (state_q == ST_DONE) & grant_q[0];
    assign wgt_done   = (state_q == ST_DONE) & grant_q[1];
    assign rmst_start = start_q;
    assign rmst_addr  = addr_q;
    assign rmst_size  = size_q;
    assign grant      = grant_q;
    assign busy       = (state_q != ST_IDLE);
    assign xfer_err   = err_q;

endmodule

// File: tb/tb_rmst_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_rmst_arbiter
// Directed self-checking bench for rmst_arbiter (default parameters:
// 64-byte beats, IFM = 720 beats, WGT = 288 beats).
// -----------------------------------------------------------------------------
module tb_rmst_arbiter;

    localparam int DW = 512;

    logic          clk = 1'b0;
    logic          rst;
    logic          ifm_req, wgt_req;
    logic [63:0]   ifm_addr_base, wgt_addr_base, ifm_offset, wgt_offset;
    logic          ifm_done, wgt_done;
    logic          ifm_tvalid, wgt_tvalid;
    logic [DW-1:0] ifm_tdata, wgt_tdata;
    logic          ifm_tready, wgt_tready;
    logic          rmst_start;
    logic [63:0]   rmst_addr, rmst_size;
    logic          rmst_done;
    logic          s_tvalid;
    logic [DW-1:0] s_tdata;
    logic          s_tready;
    logic [1:0]    grant;
    logic          busy;
    logic          xfer_err;

    int checks = 0;
    int errors = 0;

    rmst_arbiter #(
        .DATA_WIDTH    (DW),
        .IFM_XFER_BYTES(46080),
        .WGT_XFER_BYTES(18432)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ifm_req      (ifm_req),
        .wgt_req      (wgt_req),
        .ifm_addr_base(ifm_addr_base),
        .wgt_addr_base(wgt_addr_base),
        .ifm_offset   (ifm_offset),
        .wgt_offset   (wgt_offset),
        .ifm_done     (ifm_done),
        .wgt_done     (wgt_done),
        .ifm_tvalid   (ifm_tvalid),
        .wgt_tvalid   (wgt_tvalid),
        .ifm_tdata    (ifm_tdata),
        .wgt_tdata    (wgt_tdata),
        .ifm_tready   (ifm_tready),
        .wgt_tready   (wgt_tready),
        .rmst_start   (rmst_start),
        .rmst_addr    (rmst_addr),
        .rmst_size    (rmst_size),
        .rmst_done    (rmst_done),
        .s_tvalid     (s_tvalid),
        .s_tdata      (s_tdata),
        .s_tready     (s_tready),
        .grant        (grant),
        .busy         (busy),
        .xfer_err     (xfer_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge (sampling point).
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Requests already driven in IDLE: expect grant after one edge,
    // rmst_start after the second edge.
    task automatic arb(input logic [1:0] g, input logic [63:0] a, input logic [63:0] sz,
                       input string tag);
        tick();
        check({tag, "_grant"}, 64'(grant), 64'(g));
        check({tag, "_addr"},  rmst_addr, a);
        check({tag, "_size"},  rmst_size, sz);
        check({tag, "_busy"},  64'(busy), 64'd1);
        check({tag, "_start_early"}, 64'(rmst_start), 64'd0);
        tick();
        check({tag, "_start"}, 64'(rmst_start), 64'd1);
    endtask

    // Runs n beats in XFER, rmst_done on the last handshake, then checks DONE
    // and the return to IDLE.
    task automatic xfer(input logic [1:0] g, input logic [63:0] a, input logic [63:0] sz,
                        input int n, input bit toggle, input bit keep_req,
                        input bit exp_err, input string tag);
        int            delivered;
        int            cyc;
        int            bad;
        logic          rdy;
        logic [DW-1:0] d;
        delivered = 0;
        cyc       = 0;
        bad       = 0;
        s_tvalid  = 1'b1;
        while (delivered < n && cyc < 4000) begin
            rdy = toggle ? ((cyc % 3) != 1) : 1'b1;
            if (g[0]) begin
                ifm_tready = rdy;
                wgt_tready = ~rdy;
            end else begin
                wgt_tready = rdy;
                ifm_tready = ~rdy;
            end
            for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom();
            s_tdata   = d;
            rmst_done = rdy && (delivered == n - 1);
            #1;
            if (s_tready !== rdy) bad++;
            if (ifm_tvalid !== g[0] || wgt_tvalid !== g[1]) bad++;
            if (ifm_tdata !== d || wgt_tdata !== d) bad++;
            if (grant !== g || rmst_addr !== a || rmst_size !== sz || busy !== 1'b1) bad++;
            if (cyc > 0 && rmst_start !== 1'b0) bad++;
            if (ifm_done !== 1'b0 || wgt_done !== 1'b0) bad++;
            @(posedge clk);
            #1;
            cyc++;
            if (rdy) delivered++;
        end
        rmst_done  = 1'b0;
        s_tvalid   = 1'b0;
        ifm_tready = 1'b0;
        wgt_tready = 1'b0;
        check({tag, "_beats"},   64'(delivered), 64'(n));
        check({tag, "_routing"}, 64'(bad), 64'd0);
        // DONE cycle
        check({tag, "_done"}, 64'({wgt_done, ifm_done}), 64'(g));
        check({tag, "_err"},  64'(xfer_err), 64'(exp_err));
        check({tag, "_tvalid_done"}, 64'({wgt_tvalid, ifm_tvalid, s_tready}), 64'd0);
        if (!keep_req) begin
            if (g[0]) ifm_req = 1'b0;
            else      wgt_req = 1'b0;
        end
        tick();
        check({tag, "_done_clr"}, 64'({wgt_done, ifm_done}), 64'd0);
        check({tag, "_idle"},     64'({grant, busy}), 64'd0);
        check({tag, "_addr_hold"}, rmst_addr, a);
    endtask

    initial begin
        int done_seen;
        rst           = 1'b1;
        ifm_req       = 1'b0;
        wgt_req       = 1'b0;
        ifm_addr_base = 64'h0;
        wgt_addr_base = 64'h0;
        ifm_offset    = 64'h0;
        wgt_offset    = 64'h0;
        ifm_tready    = 1'b1;
        wgt_tready    = 1'b1;
        s_tvalid      = 1'b1;
        s_tdata       = '1;
        rmst_done     = 1'b0;
        #12;
        // Reset values with the stream inputs active.
        check("rst_grant", 64'(grant), 64'd0);
        check("rst_busy",  64'(busy),  64'd0);
        check("rst_start", 64'(rmst_start), 64'd0);
        check("rst_addr",  rmst_addr, 64'd0);
        check("rst_size",  rmst_size, 64'd0);
        check("rst_stream", 64'({s_tready, wgt_tvalid, ifm_tvalid}), 64'd0);
        check("rst_done",  64'({wgt_done, ifm_done}), 64'd0);
        check("rst_err",   64'(xfer_err), 64'd0);
        check("rst_tdata", 64'(ifm_tdata[63:0]), 64'hFFFF_FFFF_FFFF_FFFF);

        @(negedge clk);
        rst      = 1'b0;
        s_tvalid = 1'b0;
        tick();

        // Basic IFM transfer: 0x1000 + 0x40, full 720 beats.
        ifm_addr_base = 64'h1000;
        ifm_offset    = 64'h40;
        ifm_req       = 1'b1;
        arb(2'b01, 64'h1040, 64'd46080, "ifm1");
        xfer(2'b01, 64'h1040, 64'd46080, 720, 1'b0, 1'b0, 1'b0, "ifm1");

        // Stray rmst_done while idle is ignored.
        rmst_done = 1'b1;
        tick();
        rmst_done = 1'b0;
        check("stray_done_busy",  64'(busy), 64'd0);
        check("stray_done_start", 64'(rmst_start), 64'd0);
        check("stray_done_err",   64'(xfer_err), 64'd0);

        // WGT transfer, address wraps mod 2^64, ready toggling, 288 beats.
        wgt_addr_base = 64'hFFFF_FFFF_FFFF_FFC0;
        wgt_offset    = 64'h80;
        wgt_req       = 1'b1;
        arb(2'b10, 64'h40, 64'd18432, "wgt_wrap");
        xfer(2'b10, 64'h40, 64'd18432, 288, 1'b1, 1'b0, 1'b0, "wgt_wrap");

        // Short IFM transfer: 700 of 720 beats sets the sticky error.
        ifm_addr_base = 64'h2000;
        ifm_offset    = 64'h0;
        ifm_req       = 1'b1;
        arb(2'b01, 64'h2000, 64'd46080, "ifm_short");
        xfer(2'b01, 64'h2000, 64'd46080, 700, 1'b0, 1'b0, 1'b1, "ifm_short");

        // Good WGT transfer afterwards: error stays set.
        wgt_addr_base = 64'h8000;
        wgt_offset    = 64'h100;
        wgt_req       = 1'b1;
        arb(2'b10, 64'h8100, 64'd18432, "wgt_sticky");
        xfer(2'b10, 64'h8100, 64'd18432, 288, 1'b0, 1'b0, 1'b1, "wgt_sticky");

        // Reset in the middle of an IFM transfer.
        ifm_addr_base = 64'h3000;
        ifm_offset    = 64'h10;
        ifm_req       = 1'b1;
        arb(2'b01, 64'h3010, 64'd46080, "ifm_abort");
        s_tvalid   = 1'b1;
        ifm_tready = 1'b1;
        repeat (5) tick();
        check("abort_pre_tvalid", 64'(ifm_tvalid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("abort_busy",   64'({grant, busy}), 64'd0);
        check("abort_stream", 64'({s_tready, wgt_tvalid, ifm_tvalid}), 64'd0);
        check("abort_cmd",    rmst_addr | rmst_size, 64'd0);
        check("abort_err",    64'(xfer_err), 64'd0);
        check("abort_done",   64'({wgt_done, ifm_done, rmst_start}), 64'd0);
        s_tvalid   = 1'b0;
        ifm_tready = 1'b0;
        ifm_req    = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (ifm_done || wgt_done || busy) done_seen++;
        end
        check("abort_no_done", 64'(done_seen), 64'd0);

        // Simultaneous requests straight after reset, IFM kept high.
        ifm_addr_base = 64'h4000;
        ifm_offset    = 64'h8;
        wgt_addr_base = 64'h5000;
        wgt_offset    = 64'h20;
        ifm_req       = 1'b1;
        wgt_req       = 1'b1;
        arb(2'b01, 64'h4008, 64'd46080, "both1");
        xfer(2'b01, 64'h4008, 64'd46080, 720, 1'b0, 1'b1, 1'b0, "both1");
`ifdef RMST_ARB_RR_EN
        arb(2'b10, 64'h5020, 64'd18432, "both2");
        xfer(2'b10, 64'h5020, 64'd18432, 288, 1'b0, 1'b0, 1'b0, "both2");
`else
        arb(2'b01, 64'h4008, 64'd46080, "both2");
        xfer(2'b01, 64'h4008, 64'd46080, 720, 1'b0, 1'b0, 1'b0, "both2");
`endif
        ifm_req = 1'b0;
        wgt_req = 1'b0;
        tick();
        check("end_idle", 64'({grant, busy}), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rmst_arbiter.md
RMST_ARBITER -- requirements
Module: rmst_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, 512, stream data width in bits.
REQ-002 SHALL have parameter IFM_XFER_BYTES, 46080, bytes per IFM transfer.
REQ-003 SHALL have parameter WGT_XFER_BYTES, 18432, bytes per WGT transfer.
REQ-004 SHALL have ports:
- clk  in  1  single clock, all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- ifm_req / wgt_req  in  1  level request, held until matching done.
- ifm_addr_base / wgt_addr_base  in  64  buffer base address.
- ifm_offset / wgt_offset  in  64  address offset, valid while req high.
- ifm_done / wgt_done  out  1  one-cycle completion pulse.
- ifm_tvalid / wgt_tvalid  out  1  routed stream valid.
- ifm_tdata / wgt_tdata  out  DATA_WIDTH  routed stream data.
- ifm_tready / wgt_tready  in  1  requester stream ready.
- rmst_start  out  1  one-cycle start pulse to shared read master.
- rmst_addr  out  64  transfer address.
- rmst_size  out  64  transfer size, bytes.
- rmst_done  in  1  one-cycle read-master completion pulse.
- s_tvalid  in  1  shared stream valid.
- s_tdata  in  DATA_WIDTH  shared stream data.
- s_tready  out  1  shared stream ready.
- grant  out  2  one-hot owner: bit0 IFM, bit1 WGT.
- busy  out  1  high in any state except IDLE.
- xfer_err  out  1  sticky beat-count mismatch flag.

Function
REQ-005 SHALL implement FSM IDLE -> ISSUE -> XFER -> DONE -> IDLE.
REQ-006 IDLE: if any req high, SHALL register grant, rmst_addr = base + offset (64-bit, wraps mod 2^64), rmst_size = requester's XFER_BYTES, clear beat counter, go to ISSUE; otherwise stay.
REQ-007 ISSUE: SHALL assert rmst_start exactly one cycle, go to XFER.
REQ-008 XFER: s_tready SHALL equal granted requester's tready; granted tvalid SHALL equal s_tvalid; non-granted tvalid SHALL be 0.
REQ-009 ifm_tdata and wgt_tdata SHALL both carry s_tdata combinationally (zero latency).
REQ-010 Outside XFER, s_tready and both tvalid SHALL be 0.
REQ-011 Beat counter SHALL increment on each s_tvalid & s_tready in XFER; width sufficient for max(XFER_BYTES)/(DATA_WIDTH/8).
REQ-012 XFER on rmst_done: go to DONE; if beat count != rmst_size/(DATA_WIDTH/8), set xfer_err. A beat handshaking in the same cycle as rmst_done SHALL be counted.
REQ-013 DONE: SHALL pulse granted requester's done one cycle, clear grant, go to IDLE; requester deasserts req in that cycle.
REQ-014 rmst_addr, rmst_size SHALL be held stable from IDLE exit until return to IDLE.
REQ-015 Requests arriving while busy SHALL wait; no preemption.
REQ-016 rmst_done outside XFER SHALL be ignored.
REQ-017 Arbitration latency: req high in IDLE -> rmst_start 2 cycles later.

Reset
REQ-018 rst SHALL asynchronously force IDLE; grant=0, busy=0, rmst_start=0, rmst_addr=0, rmst_size=0, s_tready=0, all tvalid=0, both done=0, xfer_err=0, beat counter=0, RR pointer=WGT-last.
REQ-019 Reset mid-transfer SHALL abort without done pulse.

Configuration
REQ-020 With RMST_ARB_RR_EN defined: on simultaneous requests, SHALL grant the requester not granted last; pointer updated at DONE.
REQ-021 Without RMST_ARB_RR_EN: IFM SHALL win every simultaneous request; no pointer exists.

Verification
REQ-022 ifm_req=1, base=0x1000, offset=0x40 -> rmst_start 2 cycles later, rmst_addr=0x1040, rmst_size=46080, grant=01.
REQ-023 Both req high from reset, RR enabled -> IFM then WGT served; disabled, WGT held IFM high -> IFM served twice.
REQ-024 WGT transfer, 288 beats with wgt_tready toggling, then rmst_done -> 288 beats delivered, wgt_done one pulse, xfer_err=0.
REQ-025 IFM transfer, rmst_done after 700 beats (expect 720) -> xfer_err=1, stays 1 across next good transfer.
REQ-026 rst asserted during XFER -> outputs at reset values same cycle, no done pulse, next req restarts cleanly.
REQ-027 base=0xFFFF_FFFF_FFFF_FFC0, offset=0x80 -> rmst_addr=0x40.
